// File: rtl/flippy_bit_pkg.sv
// Shared types and constants for the Flippy Bit game blocks.
// Row/letter widths are common to guess_checker and Display.
package flippy_bit_pkg;

    typedef enum logic [1:0] {
        WAIT_PRESS   = 2'd0,
        CHECK        = 2'd1,
        WAIT_RELEASE = 2'd2,
        OVER         = 2'd3
    } gc_state_t;

    localparam int NUM_LETTERS             = 3;
    localparam int ROW_W                   = 5;
    localparam int LETTER_W                = 8;
    localparam int DEFAULT_FLOOR_ROW       = 29;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_CNT_W           = 19;

endpackage

// File: rtl/button_debouncer.sv
// Purpose: synchronise and debounce an active-low pushbutton; flag each new press.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles before the level/pulse moves.
// Backpressure: none; press_pulse is a single-cycle strobe.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic pressed,
    output logic press_pulse
);

    logic             sync1_n;
    logic             sync2_n;
    logic             level_n;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_n     <= 1'b1;
            sync2_n     <= 1'b1;
            level_n     <= 1'b1;
            stable_cnt  <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync1_n     <= btn_n;
            sync2_n     <= sync1_n;
            press_pulse <= 1'b0;
            // Count consecutive cycles that disagree with the accepted level;
            // any return to the old level throws the count away.
            if (sync2_n == level_n) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_n     <= sync2_n;
                stable_cnt  <= '0;
                press_pulse <= ~sync2_n;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    assign pressed = ~level_n;

endmodule

// File: rtl/guess_checker.sv
// Purpose: sample the switch guess on each debounced fire press, score it against falling letters, detect floor hits.
// Latency: correct/miss pulse two cycles after the debounced press edge; game_over one cycle after a floor tick.
// Backpressure: none; one evaluation per press, presses ignored outside WAIT_PRESS.
module guess_checker
    import flippy_bit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int FLOOR_ROW       = DEFAULT_FLOOR_ROW,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic       CLOCK_50,
    input  logic       reset_button,
    input  logic [7:0] sw,
    input  logic       fire_n,
    input  logic       tick,
    input  logic [7:0] letter1,
    input  logic [7:0] letter2,
    input  logic [7:0] letter3,
    input  logic [4:0] ypos1,
    input  logic [4:0] ypos2,
    input  logic [4:0] ypos3,
    input  logic [2:0] valid,
    output logic [2:0] correct,
    output logic       miss,
    output logic       game_over,
    output logic [7:0] guess
);

    logic                pressed;
    logic                press_pulse;
    logic [LETTER_W-1:0] sw_sync1;
    logic [LETTER_W-1:0] sw_sync2;
    gc_state_t           state;

    logic [LETTER_W-1:0]    letter_a [NUM_LETTERS];
    logic [ROW_W-1:0]       ypos_a   [NUM_LETTERS];
    logic [NUM_LETTERS-1:0] hit_sel;
    logic [NUM_LETTERS-1:0] floor_vec;
    logic [ROW_W-1:0]       best_y;
    logic                   found;
    logic                   floor_hit;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_fire_db (
        .clk         (CLOCK_50),
        .rst_n       (reset_button),
        .btn_n       (fire_n),
        .pressed     (pressed),
        .press_pulse (press_pulse)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_button) begin
        if (!reset_button) begin
            sw_sync1 <= '1;
            sw_sync2 <= '1;
        end else begin
            sw_sync1 <= sw;
            sw_sync2 <= sw_sync1;
        end
    end

    assign letter_a[0] = letter1;
    assign letter_a[1] = letter2;
    assign letter_a[2] = letter3;
    assign ypos_a[0]   = ypos1;
    assign ypos_a[1]   = ypos2;
    assign ypos_a[2]   = ypos3;

    // Deepest matching letter wins; strict '>' keeps the lowest index on a tie.
    always_comb begin
        hit_sel   = '0;
        floor_vec = '0;
        best_y    = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            floor_vec[i] = valid[i] && (ypos_a[i] >= ROW_W'(FLOOR_ROW));
            if (valid[i] && (letter_a[i] == guess) && (!found || (ypos_a[i] > best_y))) begin
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
                best_y     = ypos_a[i];
                found      = 1'b1;
            end
        end
    end

    assign floor_hit = tick && (|floor_vec);

    always_ff @(posedge CLOCK_50 or negedge reset_button) begin
        if (!reset_button) begin
            state     <= WAIT_PRESS;
            correct   <= '0;
            miss      <= 1'b0;
            game_over <= 1'b0;
            guess     <= '0;
        end else begin
            correct <= '0;
            miss    <= 1'b0;
            // A floor hit overrides whatever evaluation is in flight.
            if (floor_hit) begin
                game_over <= 1'b1;
                state     <= OVER;
            end else begin
                unique case (state)
                    WAIT_PRESS: begin
                        if (press_pulse) begin
                            guess <= sw_sync2;
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        correct <= hit_sel;
                        miss    <= ~(|hit_sel);
                        state   <= WAIT_RELEASE;
                    end
                    WAIT_RELEASE: begin
                        if (!pressed) begin
                            state <= WAIT_PRESS;
                        end
                    end
                    OVER: begin
                        state <= OVER;
                    end
                    default: begin
                        state <= WAIT_PRESS;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/guess_checker.md
Name: guess_checker

Overview:
- Player-input side of the Flippy Bit game. It debounces the fire button and samples the 8 switches on each debounced press.
- It compares the sampled byte against the three falling letters and reports hits or misses to Big_State_Machine.
- Its outputs are the producer end of the state machine's correct/game_over inputs, while Display consumes the same letter and ypos values.
- It also detects a letter reaching the floor row and raises game over.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive stable CLOCK_50 cycles needed to accept a button level (10 ms at 50 MHz).
- FLOOR_ROW, 29, last framebuffer row (40x30 grid); a valid letter with ypos >= FLOOR_ROW on a tick ends the game.
- CNT_W, 19, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; the only clock.
- reset_button  in  1  asynchronous, active-low reset.
- sw  in  8  raw slide switches; the player's guess.
- fire_n  in  1  raw fire pushbutton, active-low, asynchronous to CLOCK_50.
- tick  in  1  one-cycle game-rate enable; letters move on this pulse.
- letter1, letter2, letter3  in  8 each  target byte of each letter.
- ypos1, ypos2, ypos3  in  5 each  row of each letter.
- valid  in  3  bit i is high when letter i+1 is on screen.
- correct  out  3  one-hot, one-cycle pulse naming the destroyed letter.
- miss  out  1  one-cycle pulse: a press matched no valid letter.
- game_over  out  1  sticky level.
- guess  out  8  last sampled switch byte, for score/HEX display.

Behaviour:
- Reset (reset_button=0, asynchronous): correct=0, miss=0, game_over=0, guess=0, FSM=WAIT_PRESS, synchronisers=1 (released), debounce counter=0.
- Input conditioning:
  - fire_n and sw each pass through a 2-flop synchroniser.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of the new synchronised value.
  - Any bounce restarts the count.
- FSM states: WAIT_PRESS, CHECK, WAIT_RELEASE, OVER.
  - WAIT_PRESS: a debounced press edge in cycle N latches the synchronised sw into guess at edge N+1 and moves to CHECK.
  - CHECK (one cycle): evaluates the match. correct or miss is asserted for exactly one cycle starting at edge N+2. Then go to WAIT_RELEASE.
  - WAIT_RELEASE: holds until the debounced level is released, then returns to WAIT_PRESS. This gives one evaluation per press; holding the button never repeats.
  - OVER: absorbing state. correct and miss are held at 0 and presses are ignored. Only reset leaves it.
- Match rule:
  - Candidates are letters with valid[i]=1 and letter == guess (full 8-bit equality).
  - Among candidates, the one with the largest ypos wins. On a ypos tie, the lowest index wins.
  - No candidate gives miss=1 and correct=0.
  - valid=0 letters never match, even if equal.
- Floor check:
  - Evaluated only in cycles where tick=1.
  - Any letter with valid[i]=1 and ypos >= FLOOR_ROW sets game_over=1 at the next edge and forces the FSM to OVER from any state.
- Simultaneous events:
  - tick-triggered floor hit in the same cycle as CHECK: game_over wins, correct and miss stay 0.
  - tick without a floor hit during CHECK: no effect on the evaluation.
- Reset mid-press: all state clears. If the button is still held after reset, the debouncer first sees "pressed" as a new level change, and that counts as one press once stable.
- game_over is not cleared by valid going low; only reset clears it.

Decomposition:
- Package flippy_bit_pkg:
  - FSM state enum (2 bits).
  - NUM_LETTERS=3.
  - Default FLOOR_ROW and DEBOUNCE_CYCLES constants.
  - Row and letter width constants (5, 8), shared with Display.
- One sub-module, button_debouncer:
  - Contains the synchroniser, stable-count logic and edge detection.
  - Parameter DEBOUNCE_CYCLES.
  - Outputs a debounced level and a press-edge pulse.
- The FSM and match priority logic stay in guess_checker.

Test Plan:
Benches use DEBOUNCE_CYCLES=4.
- Hit, deepest letter wins:
  - Stimulus: letters 0x5A/0x5A/0x13, ypos 3/7/2, valid=111, sw=0x5A, clean press.
  - Required: correct=010 for exactly one cycle, 2 cycles after the debounced edge; miss=0; guess=0x5A.
- Miss and ypos tie:
  - Stimulus: sw=0xFF with no matching letter.
  - Required: miss pulse of one cycle, correct=000.
  - Stimulus: letters 1 and 3 both 0x21 at ypos 5, sw=0x21.
  - Required: correct=001.
- Bounce and hold:
  - Stimulus: fire_n toggles every 2 cycles for 20 cycles, then held low for 200 cycles.
  - Required: exactly one correct/miss pulse; nothing further until release and a new press.
- Floor:
  - Stimulus: valid letter at ypos=29 with tick=1.
  - Required: game_over=1 next cycle and remains 1; later presses give no pulses.
  - Stimulus: ypos=29 with valid=0.
  - Required: no game_over.
- Collision:
  - Stimulus: tick with a floor hit in the same cycle as CHECK for a matching press.
  - Required: game_over=1, correct=000, miss=0.
- Async reset:
  - Stimulus: reset_button low mid-WAIT_RELEASE, off a clock edge.
  - Required: all outputs 0 immediately; after release, a stable held button produces one new evaluation.
